// File: rtl/tx_arbiter.sv
// tx_arbiter
//
// Shares one UART transmitter between two byte sources: the CPU output
// path and a debug/status source.
//
// The CPU path reacts to the falling edge of the slow, active-low CPU TX
// line. Each CPU byte goes into a small circular FIFO so that several output
// instructions in a row are not lost while the UART is still sending. The
// debug path has a single holding register. A round-robin arbiter issues
// exactly one one-cycle strobe per byte. It then follows the transmitter's
// busy line before it issues the next byte.
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_cpu_tx      CPU TX line, active low (slow relative to i_clk)
//   i_cpu_data    CPU byte, valid while i_cpu_tx is low
//   i_dbg_stb     one-cycle debug byte request
//   i_dbg_data    debug byte, sampled with i_dbg_stb
//   o_dbg_busy    debug holding register full; i_dbg_stb ignored while high
//   o_tx_stb      one-cycle strobe to the transmitter
//   o_tx_data     byte to the transmitter, valid with o_tx_stb
//   i_tx_busy     transmitter busy
//   o_fifo_count  number of bytes held in the CPU FIFO
//   o_overflow    sticky: a CPU byte was dropped because the FIFO was full

module tx_arbiter #(
    parameter int LGDEPTH      = 2,
    parameter int BUSY_TIMEOUT = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cpu_tx,
    input  logic [7:0]         i_cpu_data,
    input  logic               i_dbg_stb,
    input  logic [7:0]         i_dbg_data,
    output logic               o_dbg_busy,
    output logic               o_tx_stb,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_busy,
    output logic [LGDEPTH:0]   o_fifo_count,
    output logic               o_overflow
);

    localparam int DEPTH = 1 << LGDEPTH;
    localparam int CW    = LGDEPTH + 1;
    localparam int TW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    logic                prev_tx_q,  prev_tx_d;
    logic [7:0]          mem_q [DEPTH];
    logic [7:0]          mem_d [DEPTH];
    logic [LGDEPTH-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [LGDEPTH-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]       count_q,    count_d;
    logic                overflow_q, overflow_d;
    logic                dbg_busy_q, dbg_busy_d;
    logic [7:0]          dbg_data_q, dbg_data_d;
    logic [1:0]          state_q,    state_d;
    logic [TW-1:0]       timer_q,    timer_d;
    logic                last_dbg_q, last_dbg_d;
    logic                tx_stb_q,   tx_stb_d;
    logic [7:0]          tx_data_q,  tx_data_d;

    logic push;
    logic push_ok;
    logic pop;
    logic fifo_full;
    logic cpu_pend;
    logic grant;
    logic grant_cpu;
    logic grant_dbg;

    // Arbitration. last_dbg_q records whether the previous grant went to the
    // debug source. When both sources are pending, the CPU wins only if debug
    // was granted last. last_dbg_q resets to 1, so the CPU is favoured first.
    always_comb begin
        cpu_pend  = (count_q != '0);
        fifo_full = (count_q == CW'(DEPTH));
        grant     = (state_q == S_IDLE) && !i_tx_busy && (cpu_pend || dbg_busy_q);
        grant_cpu = grant && cpu_pend && (!dbg_busy_q || last_dbg_q);
        grant_dbg = grant && !grant_cpu;
        pop       = grant_cpu;
    end

    // Transmit FSM. The FSM waits in IDLE while the UART is busy. This covers
    // a reset that lands mid-character, because txuart itself is not reset.
    // If busy never rises after a strobe, the byte is treated as sent once
    // the timeout expires.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last_dbg_d = last_dbg_q;
        tx_stb_d   = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    tx_stb_d   = 1'b1;
                    tx_data_d  = grant_cpu ? mem_q[rd_ptr_q] : dbg_data_q;
                    last_dbg_d = grant_dbg;
                    timer_d    = '0;
                    state_d    = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // CPU capture and FIFO. A push happens on the high-to-low transition of
    // the CPU TX line. A push into a full FIFO is still accepted when a pop
    // happens in the same cycle. When full, the write and read slots
    // coincide, but the popped byte has already been read combinationally
    // into tx_data_d.
    always_comb begin
        prev_tx_d  = i_cpu_tx;
        push       = prev_tx_q && !i_cpu_tx;
        push_ok    = push && (!fifo_full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        count_d    = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = i_cpu_data;
            wr_ptr_d        = wr_ptr_q + LGDEPTH'(1);
        end else if (push) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + LGDEPTH'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Debug holding register. A grant needs the register to be full, and a
    // load needs it to be empty, so the two can never happen together.
    always_comb begin
        dbg_busy_d = dbg_busy_q;
        dbg_data_d = dbg_data_q;
        if (grant_dbg) begin
            dbg_busy_d = 1'b0;
        end else if (i_dbg_stb && !dbg_busy_q) begin
            dbg_busy_d = 1'b1;
            dbg_data_d = i_dbg_data;
        end
    end

    // State registers. Reset takes priority over any push, strobe or grant
    // in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_tx_q  <= 1'b1;
            mem_q      <= '{default: 8'h00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dbg_busy_q <= 1'b0;
            dbg_data_q <= 8'h00;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            last_dbg_q <= 1'b1;
            tx_stb_q   <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            prev_tx_q  <= prev_tx_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dbg_busy_q <= dbg_busy_d;
            dbg_data_q <= dbg_data_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            last_dbg_q <= last_dbg_d;
            tx_stb_q   <= tx_stb_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign o_dbg_busy   = dbg_busy_q;
    assign o_tx_stb     = tx_stb_q;
    assign o_tx_data    = tx_data_q;
    assign o_fifo_count = count_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter
//
// Bench for tx_arbiter. Expected bytes are queued when stimulus is issued.
// A monitor pops and compares one byte on every o_tx_stb. A small txuart
// model raises busy one cycle after each strobe for busy_len cycles. The
// stimulus can also force busy high, or stop busy from ever rising.

module tb_tx_arbiter;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_cpu_tx;
    logic [7:0] i_cpu_data;
    logic       i_dbg_stb;
    logic [7:0] i_dbg_data;
    logic       o_dbg_busy;
    logic       o_tx_stb;
    logic [7:0] o_tx_data;
    logic       i_tx_busy;
    logic [2:0] o_fifo_count;
    logic       o_overflow;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;

    logic [7:0] exp_q[$];

    logic force_busy    = 1'b0;
    logic no_busy       = 1'b0;
    logic model_busy    = 1'b0;
    logic start_pending = 1'b0;
    int   busy_len      = 20;
    int   busy_left     = 0;

    int   last_stb_cyc  = -10;
    int   prev_stb_cyc  = -10;
    logic prev_stb      = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign i_tx_busy = force_busy | model_busy;

    tx_arbiter #(
        .LGDEPTH      (2),
        .BUSY_TIMEOUT (3)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_cpu_tx     (i_cpu_tx),
        .i_cpu_data   (i_cpu_data),
        .i_dbg_stb    (i_dbg_stb),
        .i_dbg_data   (i_dbg_data),
        .o_dbg_busy   (o_dbg_busy),
        .o_tx_stb     (o_tx_stb),
        .o_tx_data    (o_tx_data),
        .i_tx_busy    (i_tx_busy),
        .o_fifo_count (o_fifo_count),
        .o_overflow   (o_overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One CPU edge (is_dbg=0), or one debug strobe (is_dbg=1).
    task automatic applyStimulus(input logic is_dbg, input logic [7:0] data);
        tick();
        if (is_dbg) begin
            i_dbg_data = data;
            i_dbg_stb  = 1'b1;
        end else begin
            i_cpu_data = data;
            i_cpu_tx   = 1'b0;
        end
        tick();
        i_dbg_stb = 1'b0;
        i_cpu_tx  = 1'b1;
    endtask

    task automatic do_reset();
        tick();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (n < 3000 && !(exp_q.size() == 0 && !i_tx_busy &&
                             o_fifo_count == 3'd0 && !o_dbg_busy)) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(n < 3000), 32'd1);
        repeat (8) tick();
    endtask

    // txuart model: busy rises one cycle after a strobe and lasts busy_len cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start_pending) begin
                model_busy    = 1'b1;
                busy_left     = busy_len;
                start_pending = 1'b0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) model_busy = 1'b0;
            end
            if (o_tx_stb && !no_busy) start_pending = 1'b1;
        end
    end

    // Monitor: every strobe must be expected, match the queue head, and not
    // follow another strobe in the previous cycle.
    always @(negedge clk) begin
        if (o_tx_stb) begin
            checkOutput("stb_not_back_to_back", 32'(prev_stb), 32'd0);
            checkOutput("stb_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                checkOutput("tx_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
            end
            prev_stb_cyc = last_stb_cyc;
            last_stb_cyc = cyc;
        end
        prev_stb = o_tx_stb;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;
        logic prev_db;

        i_reset    = 1'b0;
        i_cpu_tx   = 1'b1;
        i_cpu_data = 8'h00;
        i_dbg_stb  = 1'b0;
        i_dbg_data = 8'h00;

        // Reset values
        do_reset();
        @(negedge clk);
        checkOutput("rst_tx_stb",   32'(o_tx_stb),     32'd0);
        checkOutput("rst_tx_data",  32'(o_tx_data),    32'h00);
        checkOutput("rst_dbg_busy", 32'(o_dbg_busy),   32'd0);
        checkOutput("rst_count",    32'(o_fifo_count), 32'd0);
        checkOutput("rst_overflow", 32'(o_overflow),   32'd0);

        // Single CPU byte: strobe two cycles after the sampled edge; held low gives one push
        busy_len = 100;
        exp_q.push_back(8'h5A);
        tick();
        i_cpu_data = 8'h5A;
        i_cpu_tx   = 1'b0;
        @(negedge clk);
        checkOutput("t1_count_k",  32'(o_fifo_count), 32'd0);
        @(negedge clk);
        checkOutput("t1_count_k1", 32'(o_fifo_count), 32'd1);
        checkOutput("t1_stb_k1",   32'(o_tx_stb),     32'd0);
        @(negedge clk);
        checkOutput("t1_stb_k2",   32'(o_tx_stb),     32'd1);
        checkOutput("t1_count_k2", 32'(o_fifo_count), 32'd0);
        repeat (50) tick();
        i_cpu_tx = 1'b1;
        drain("t1_drain");
        busy_len = 20;

        // Arbitration: CPU first after reset, then debug, then CPU
        do_reset();
        force_busy = 1'b1;
        applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h22);
        applyStimulus(1'b1, 8'hDD);
        checkOutput("t3_count",    32'(o_fifo_count), 32'd2);
        checkOutput("t3_dbg_busy", 32'(o_dbg_busy),   32'd1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'hDD);
        exp_q.push_back(8'h22);
        force_busy = 1'b0;
        found   = 1'b0;
        prev_db = 1'b1;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (o_tx_stb && o_tx_data == 8'hDD) begin
                found = 1'b1;
                checkOutput("t3_dbg_busy_at_stb",  32'(o_dbg_busy), 32'd0);
                checkOutput("t3_dbg_busy_before",  32'(prev_db),    32'd1);
            end
            prev_db = o_dbg_busy;
        end
        checkOutput("t3_dd_seen", 32'(found), 32'd1);
        drain("t3_drain");

        // Debug strobe while the holding register is full is ignored
        do_reset();
        force_busy = 1'b1;
        applyStimulus(1'b1, 8'hAA);
        checkOutput("t4_dbg_busy_a", 32'(o_dbg_busy), 32'd1);
        applyStimulus(1'b1, 8'hBB);
        checkOutput("t4_dbg_busy_b", 32'(o_dbg_busy), 32'd1);
        exp_q.push_back(8'hAA);
        force_busy = 1'b0;
        drain("t4_drain");

        // Full FIFO: push and grant pop in the same cycle
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'(8'h31 + i));
            exp_q.push_back(8'(8'h31 + i));
        end
        checkOutput("t5_full_count", 32'(o_fifo_count), 32'd4);
        tick();
        i_cpu_data = 8'h35;
        i_cpu_tx   = 1'b0;
        force_busy = 1'b0;
        exp_q.push_back(8'h35);
        tick();
        i_cpu_tx = 1'b1;
        @(negedge clk);
        checkOutput("t5_count_after", 32'(o_fifo_count), 32'd4);
        checkOutput("t5_overflow",    32'(o_overflow),   32'd0);
        drain("t5_drain");

        // Burst of six while busy: four kept, two dropped, overflow sticky
        do_reset();
        force_busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 8'(i));
            if (i <= 4) exp_q.push_back(8'(i));
            if (i == 4) begin
                checkOutput("t2_count_4",    32'(o_fifo_count), 32'd4);
                checkOutput("t2_overflow_4", 32'(o_overflow),   32'd0);
            end
        end
        checkOutput("t2_count_6",    32'(o_fifo_count), 32'd4);
        checkOutput("t2_overflow_6", 32'(o_overflow),   32'd1);
        force_busy = 1'b0;
        drain("t2_drain");
        checkOutput("t2_overflow_sticky", 32'(o_overflow), 32'd1);

        // Reset while busy with data queued; edge during reset ignored, low after reset counts
        do_reset();
        force_busy = 1'b1;
        applyStimulus(1'b0, 8'h41);
        applyStimulus(1'b0, 8'h42);
        checkOutput("t6_count_pre", 32'(o_fifo_count), 32'd2);
        tick();
        i_reset    = 1'b1;
        i_cpu_data = 8'h43;
        i_cpu_tx   = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        @(negedge clk);
        checkOutput("t6_count_reset", 32'(o_fifo_count), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("t6_count_after_edge", 32'(o_fifo_count), 32'd1);
        i_cpu_tx = 1'b1;
        repeat (10) tick();
        exp_q.push_back(8'h43);
        force_busy = 1'b0;
        drain("t6_drain");

        // Busy never rises: timeout returns to IDLE and the next byte follows
        do_reset();
        no_busy = 1'b1;
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h52);
        applyStimulus(1'b0, 8'h51);
        applyStimulus(1'b0, 8'h52);
        drain("t6b_drain");
        checkOutput("t6b_stb_gap", 32'(last_stb_cyc - prev_stb_cyc), 32'd4);
        no_busy = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
